seq_set_compare: RTL and testbench

Multi-cycle, parametrised set-on-condition unit for the ALU datapath. It generalises the combinational less/equal condition selector to arbitrary operand width, with selectable signed or unsigned comparison. It scans operands MSB-first, CHUNK bits per cycle, exits early at the first differing chunk, and returns the zero-extended set result through a start/done handshake. It sits beside the ALU and feeds the set-instruction write-back mux.

---
 rtl/seq_set_compare.sv | 134 +++++++++++++
 tb/tb_seq_set_compare.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seq_set_compare.sv
// seq_set_compare: multi-cycle set-on-condition unit.
// Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and stops
// at the first differing chunk. Signed compares are turned into unsigned ones
// by flipping the sign bit of both operands when they are latched.
// Ports:
//   clk_i, rst_i        clock, synchronous active-low reset
//   start_i             request, accepted in IDLE or DONE
//   src1_i, src2_i      operands A and B
//   cond_i              condition code (lt/gt/le/ge/eq/ne)
//   signed_i            two's-complement compare when SIGNED_EN=1
//   busy_o              high while scanning
//   done_o              one-cycle result-valid pulse
//   result_o            zero-extended set bit
//   less_o, equal_o     A<B and A==B from the last completed compare
module seq_set_compare #(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [2:0]       cond_i,
  input  logic             signed_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             less_o,
  output logic             equal_o
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       cond_q;
  logic [IW-1:0]    idx;
  logic             less_q, equal_q, set_q;
  logic [CHUNK-1:0] ca, cb;
  logic             sgn, accept, fin, differ, last;
  logic             less_nxt, equal_nxt, set_nxt;

  // Operands are shifted left each scan cycle, so the chunk under test is
  // always the top CHUNK bits.
  assign ca        = a_q[WIDTH-1 -: CHUNK];
  assign cb        = b_q[WIDTH-1 -: CHUNK];
  assign sgn       = signed_i & (SIGNED_EN != 0);
  assign differ    = (ca != cb);
  assign last      = (idx == IW'(NCH - 1));
  assign less_nxt  = differ & (ca < cb);
  assign equal_nxt = ~differ;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (start_i) begin
        accept    = 1'b1;
        state_nxt = SCAN;
      end
      SCAN: if (differ || last) begin
        fin       = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (start_i) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    set_nxt = 1'b0;
    case (cond_q)
      3'b000: set_nxt = less_nxt & ~equal_nxt;
      3'b001: set_nxt = ~less_nxt & ~equal_nxt;
      3'b010: set_nxt = less_nxt | equal_nxt;
      3'b011: set_nxt = ~less_nxt | equal_nxt;
      3'b110: set_nxt = equal_nxt;
      3'b100: set_nxt = ~equal_nxt;
      default: set_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      cond_q  <= '0;
      idx     <= '0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
      set_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= {src1_i[WIDTH-1] ^ sgn, src1_i[WIDTH-2:0]};
        b_q    <= {src2_i[WIDTH-1] ^ sgn, src2_i[WIDTH-2:0]};
        cond_q <= cond_i;
        idx    <= '0;
      end else if (state == SCAN && !fin) begin
        a_q <= a_q << CHUNK;
        b_q <= b_q << CHUNK;
        idx <= idx + IW'(1);
      end
      if (fin) begin
        less_q  <= less_nxt;
        equal_q <= equal_nxt;
        set_q   <= set_nxt;
      end
    end
  end

  assign busy_o   = (state == SCAN);
  assign done_o   = (state == DONE);
  assign result_o = {{(WIDTH-1){1'b0}}, set_q};
  assign less_o   = less_q;
  assign equal_o  = equal_q;

endmodule

// File: tb/tb_seq_set_compare.sv
// Directed bench for seq_set_compare (WIDTH=32, CHUNK=8, SIGNED_EN=1).
module tb_seq_set_compare;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] src1_i, src2_i;
  logic [2:0]  cond_i;
  logic        signed_i;
  logic        busy_o, done_o, less_o, equal_o;
  logic [31:0] result_o;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk_i = ~clk_i;

  seq_set_compare #(.WIDTH(32), .CHUNK(8), .SIGNED_EN(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .src1_i(src1_i), .src2_i(src2_i), .cond_i(cond_i), .signed_i(signed_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .less_o(less_o), .equal_o(equal_o)
  );

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  cond;
    logic        sg;
    int          edges;
    logic        less, eq;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE/DONE; return edges from accept to done and the
  // number of busy cycles seen in between.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic sg,
                        output int edges, output int busy_cnt);
    src1_i = a; src2_i = b; cond_i = c; signed_i = sg; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    edges = 0; busy_cnt = 0;
    while (!done_o && edges < 20) begin
      if (busy_o) busy_cnt++;
      @(posedge clk_i); #1;
      edges++;
    end
  endtask

  initial begin
    int e, bc;
    vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 3'b000, 1'b1, 1, 1'b1, 1'b0, 32'h1};
    vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 3'b000, 1'b0, 1, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 3'b001, 1'b0, 1, 1'b0, 1'b0, 32'h1};
    vecs[3]  = '{32'h12345678, 32'h12345678, 3'b110, 1'b0, 4, 1'b0, 1'b1, 32'h1};
    vecs[4]  = '{32'h12345678, 32'h12345678, 3'b100, 1'b0, 4, 1'b0, 1'b1, 32'h0};
    vecs[5]  = '{32'h12345678, 32'h12345678, 3'b111, 1'b0, 4, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{32'h00000005, 32'h00000007, 3'b011, 1'b0, 4, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{32'h00000005, 32'h00000007, 3'b010, 1'b0, 4, 1'b1, 1'b0, 32'h1};
    vecs[8]  = '{32'h80000000, 32'h7FFFFFFF, 3'b000, 1'b1, 1, 1'b1, 1'b0, 32'h1};
    vecs[9]  = '{32'h00000005, 32'h00000007, 3'b001, 1'b1, 4, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{32'h12345600, 32'h12345700, 3'b101, 1'b0, 3, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{32'h00010000, 32'h00000000, 3'b001, 1'b0, 2, 1'b0, 1'b0, 32'h1};

    rst_i = 1'b0; start_i = 1'b0; src1_i = '0; src2_i = '0; cond_i = '0; signed_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_done", {31'b0, done_o}, 32'h0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_less", {31'b0, less_o}, 32'h0);
    chk("rst_equal", {31'b0, equal_o}, 32'h0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cond, vecs[i].sg, e, bc);
      chk($sformatf("v%0d_edges", i), e, vecs[i].edges);
      chk($sformatf("v%0d_busy", i), bc, vecs[i].edges);
      chk($sformatf("v%0d_less", i), {31'b0, less_o}, {31'b0, vecs[i].less});
      chk($sformatf("v%0d_equal", i), {31'b0, equal_o}, {31'b0, vecs[i].eq});
      chk($sformatf("v%0d_result", i), result_o, vecs[i].res);
      @(posedge clk_i); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'b0, done_o}, 32'h0);
    end

    // start during SCAN ignored, then back-to-back accept from DONE
    src1_i = 32'h5; src2_i = 32'h7; cond_i = 3'b010; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    src1_i = 32'hFFFFFFFF; src2_i = 32'h0; cond_i = 3'b000; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    e = 2;
    while (!done_o && e < 20) begin
      @(posedge clk_i); #1;
      e++;
    end
    chk("ign_edges", e, 4);
    chk("ign_less", {31'b0, less_o}, 32'h1);
    chk("ign_result", result_o, 32'h1);
    src1_i = 32'h2; src2_i = 32'h1; cond_i = 3'b001; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("b2b_busy", {31'b0, busy_o}, 32'h1);
    chk("b2b_done", {31'b0, done_o}, 32'h0);
    e = 0;
    while (!done_o && e < 20) begin
      @(posedge clk_i); #1;
      e++;
    end
    chk("b2b_edges", e, 4);
    chk("b2b_less", {31'b0, less_o}, 32'h0);
    chk("b2b_result", result_o, 32'h1);
    @(posedge clk_i); #1;

    // reset in the second SCAN cycle of an equal compare aborts it
    src1_i = 32'h12345678; src2_i = 32'h12345678; cond_i = 3'b110; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    chk("abort_busy_pre", {31'b0, busy_o}, 32'h1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    chk("abort_busy", {31'b0, busy_o}, 32'h0);
    chk("abort_done", {31'b0, done_o}, 32'h0);
    chk("abort_result", result_o, 32'h0);
    chk("abort_less", {31'b0, less_o}, 32'h0);
    chk("abort_equal", {31'b0, equal_o}, 32'h0);
    bc = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) bc++;
    end
    chk("abort_no_done", bc, 0);
    run_op(32'h12345678, 32'h12345678, 3'b110, 1'b0, e, bc);
    chk("fresh_edges", e, 4);
    chk("fresh_equal", {31'b0, equal_o}, 32'h1);
    chk("fresh_result", result_o, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
